clock_divide_by_n: RTL and testbench
====================================

// Module: clock_divide_by_n
// PURPOSE
//  Programmable clock divider, divides clkin by N (2..2^DIV_W-1) with 50% duty for even and odd N.
//  Odd N uses a negedge half-cycle path, even N posedge only. Divisor is changed at runtime
//  without glitches, with a graceful enable. Feeds low-rate peripheral clocks and strobes.
// PARAMETERS
//  DIV_W        4   width of divisor input and phase counter
//  DEFAULT_DIV  3   divisor used from reset until the first div load; clamped as below
// PORTS
//  clkin    in   1      source clock; all state on posedge except n_hi (negedge)
//  reset    in   1      asynchronous, active-low reset (0 = reset)
//  en       in   1      1 = run; 0 = stop clkout low at next period boundary
//  div      in   DIV_W  requested divisor N; sampled only at period boundary
//  clkout   out  1      divided clock, 50% duty
//  tick     out  1      1-clkin-cycle pulse, high in the cycle clkout rises
//  div_act  out  DIV_W  divisor currently in effect (clamped)
// BEHAVIOUR
//  - Reset (reset=0, async): ctr=0, p_hi=0, n_hi=0, tick=0, clkout=0, running=0,
//    div_act=clamp(DEFAULT_DIV). Outputs stay so while reset=0.
//  - clamp(x): x<2 -> 2, else x. Applied to div and DEFAULT_DIV. H = div_act>>1.
//  - Period boundary: posedge where (running && ctr==div_act-1) or (!running && en).
//    At boundary: if en, div_act<=clamp(div), ctr<=0, p_hi<=1, tick<=1, running<=1.
//    If !en, ctr<=0, p_hi<=0, running<=0. Clock stays low with no partial pulse.
//  - Otherwise, while running: ctr<=ctr+1, p_hi<=(ctr+1 < H), tick<=0.
//  - n_hi: negedge flop, n_hi<=p_hi. odd_q = div_act[0].
//  - clkout = p_hi | (odd_q & n_hi). Both terms come from flops. odd_q changes only at
//    boundary, when n_hi=0, so there is no glitch.
//  - High time: even N -> N/2 clkin cycles. Odd N -> (N-1)/2 + 0.5 cycles. Period exactly N.
//  - Latency: first clkout rise and tick at the first posedge with en=1 after reset is released.
//  - div changes mid-period: ignored until the next boundary. The current period completes
//    with the old N.
//  - en drops mid-period: the current period completes, then clkout is held 0.
//    When en rises again, a new period starts at the next posedge.
//  - reset asserted mid-period: clkout drops to 0 immediately (async). This may produce a
//    runt pulse, and the consumer must be held in reset too.
//  - ctr never exceeds div_act-1. Adding 1 to ctr never wraps because div_act <= 2^DIV_W-1.
// CONFIGURATION
//  CLKDIV_RST_SYNC_EN defined:
//    - reset feeds a 2-flop deassertion synchroniser (assert async, release after 2 clkin posedges).
//    - All internal flops, including the negedge one, use the synchronised reset.
//    - First clkout rise is 2 clkin cycles later than without the macro.
//  Not defined: reset drives all flops directly, and the caller guarantees a synchronous release.
// STRUCTURE
//  clkdiv_pkg: localparam DIV_MIN=2, function clamp_div(), typedef logic [DIV_W-1:0] div_t.
//  Sub-module clkdiv_rst_sync (2-flop async-assert/sync-release). It is instantiated only
//  under CLKDIV_RST_SYNC_EN.
//  Top holds the counter, p_hi/n_hi/tick flops and the output OR. No other sub-modules.
// TESTING
//  1 Reset: reset=0 for 5 cycles with en=1, div=4 -> clkout=0, tick=0, div_act=3
//    (DEFAULT_DIV) throughout.
//  2 Even: en=1, div=4 -> period 4 cycles, high 2.0; one tick per period aligned to the
//    clkout rise; duty 50% over 20 periods.
//  3 Odd: div=5 -> period 5 cycles, high 2.5 (falls on a negedge); div=3 -> high 1.5;
//    div=0/1 -> behaves as div=2, div_act=2.
//  4 Runtime change: div 4->7 at mid-period -> current period 4 cycles, next period 7;
//    no pulse narrower than min(high times); div_act updates at the boundary.
//  5 Enable: en=0 mid-period (div=6) -> the period finishes, then clkout stays 0 with no
//    tick. en=1 -> rise at the next posedge.
//  6 Async reset mid-period, and the macro build: reset=0 between edges -> clkout=0 with no
//    clkin edge. With CLKDIV_RST_SYNC_EN, the first rise comes 2 cycles later than without it.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// ============================================================================
// Module : clkdiv_pkg
// Brief  : Shared constants, divisor type and clamp helper for the divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clkdiv_pkg;

  localparam int DIV_MIN    = 2;
  localparam int DIV_W_DFLT = 4;

  typedef logic [DIV_W_DFLT-1:0] div_t;

  // Divisors below DIV_MIN cannot give a 50% clock; run them as DIV_MIN.
  function automatic int clamp_div(input int x);
    return (x < DIV_MIN) ? DIV_MIN : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clkdiv_rst_sync.sv
// ============================================================================
// Module : clkdiv_rst_sync
// Brief  : 2-flop reset synchroniser, async assert / sync release.
//          Only compiled when CLKDIV_RST_SYNC_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef CLKDIV_RST_SYNC_EN
module clkdiv_rst_sync (
  input  logic clk,
  input  logic rst_n_async,
  output logic rst_n_sync
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n_async) begin
    if (!rst_n_async) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  assign rst_n_sync = sync[1];

endmodule
`endif

`default_nettype wire

// File: rtl/clock_divide_by_n.sv
// ============================================================================
// Module : clock_divide_by_n
// Brief  : Programmable 50%-duty clock divider (N = 2..2^DIV_W-1), glitch-free
//          runtime divisor change and graceful enable. Macro: CLKDIV_RST_SYNC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_divide_by_n #(
  parameter int DIV_W       = 4,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             clkout,
  output logic             tick,
  output logic [DIV_W-1:0] div_act
);

  import clkdiv_pkg::*;

  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(clamp_div(DEFAULT_DIV));

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic             rst_n;
  logic [0:0]       state, state_nxt;
  logic [DIV_W-1:0] ctr, ctr_nxt, ctr_inc, half;
  logic [DIV_W-1:0] div_act_nxt;
  logic             p_hi, p_hi_nxt, n_hi, tick_nxt, boundary;

`ifdef CLKDIV_RST_SYNC_EN
  clkdiv_rst_sync u_rst_sync (
    .clk         (clkin),
    .rst_n_async (reset),
    .rst_n_sync  (rst_n)
  );
`else
  assign rst_n = reset;
`endif

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ctr     <= '0;
      p_hi    <= 1'b0;
      tick    <= 1'b0;
      div_act <= DIV_RESET;
    end else begin
      state   <= state_nxt;
      ctr     <= ctr_nxt;
      p_hi    <= p_hi_nxt;
      tick    <= tick_nxt;
      div_act <= div_act_nxt;
    end
  end

  // Half-cycle extension for odd divisors.
  always_ff @(negedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      n_hi <= 1'b0;
    end else begin
      n_hi <= p_hi;
    end
  end

  always_comb begin
    state_nxt   = state;
    ctr_nxt     = ctr;
    p_hi_nxt    = p_hi;
    tick_nxt    = 1'b0;
    div_act_nxt = div_act;
    half        = div_act >> 1;
    ctr_inc     = ctr + 1'b1;
    boundary    = (state == ST_RUN) ? (ctr == div_act - 1'b1) : en;
    if (boundary) begin
      ctr_nxt = '0;
      if (en) begin
        div_act_nxt = DIV_W'(clamp_div(int'(div)));
        p_hi_nxt    = 1'b1;
        tick_nxt    = 1'b1;
        state_nxt   = ST_RUN;
      end else begin
        p_hi_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    end else if (state == ST_RUN) begin
      ctr_nxt  = ctr_inc;
      p_hi_nxt = (ctr_inc < half);
    end
  end

  // odd_q (div_act[0]) only moves at a boundary, where n_hi is already 0.
  always_comb begin
    clkout = p_hi | (div_act[0] & n_hi);
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_divide_by_n.sv
// ============================================================================
// Module : tb_clock_divide_by_n
// Brief  : Randomised self-checking bench with a half-cycle waveform model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clock_divide_by_n;

  localparam int DIV_W       = 4;
  localparam int DEFAULT_DIV = 3;
`ifdef CLKDIV_RST_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  logic             clkin = 1'b0;
  logic             reset = 1'b1;
  logic             en    = 1'b0;
  logic [DIV_W-1:0] div   = '0;
  logic             clkout, tick;
  logic [DIV_W-1:0] div_act;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;
  int hi_cnt = 0;

  // Model: a running period of length m_n, currently in clkin cycle m_pos.
  // clkout is high for the first m_n half-cycles of each period.
  bit m_active;
  int m_n, m_pos, m_hold;

  clock_divide_by_n #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clkin   (clkin),
    .reset   (reset),
    .en      (en),
    .div     (div),
    .clkout  (clkout),
    .tick    (tick),
    .div_act (div_act)
  );

  always #5 clkin = ~clkin;

  function automatic int clampn(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_n      = clampn(DEFAULT_DIV);
    m_pos    = 0;
    m_hold   = SYNC_DLY;
  endtask

  task automatic cycle();
    @(posedge clkin);
    if (!reset) begin
      model_reset();
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_active && m_pos < m_n - 1) begin
      m_pos++;
    end else if (m_active || en) begin
      m_pos = 0;
      if (en) begin
        m_active = 1'b1;
        m_n      = clampn(int'(div));
      end else begin
        m_active = 1'b0;
      end
    end
    #2;
    chk("clkout_first_half", clkout, m_active && (2 * m_pos < m_n));
    chk("tick_first_half", tick, m_active && (m_pos == 0));
    chk("div_act", div_act, m_n);
    if (tick === 1'b1) tick_cnt++;
    if (clkout === 1'b1) hi_cnt++;
    @(negedge clkin);
    #2;
    chk("clkout_second_half", clkout, m_active && (2 * m_pos + 1 < m_n));
    chk("tick_second_half", tick, m_active && (m_pos == 0));
    if (clkout === 1'b1) hi_cnt++;
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    chk("async_rst_clkout", clkout, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_div_act", div_act, clampn(DEFAULT_DIV));
    model_reset();
  endtask

  initial begin
    model_reset();
    en  = 1'b1;
    div = 4'd4;
    #1 reset = 1'b0;
    repeat (5) cycle();
    reset = 1'b1;

    // Steady div=4: 20 periods -> 20 ticks, half of all samples high.
    repeat (8) cycle();
    tick_cnt = 0;
    hi_cnt   = 0;
    repeat (80) cycle();
    chk("ticks_in_20_periods", tick_cnt, 20);
    chk("high_half_samples", hi_cnt, 80);

    div = 4'd5; repeat (30) cycle();
    div = 4'd3; repeat (30) cycle();
    div = 4'd0; repeat (20) cycle();
    div = 4'd1; repeat (20) cycle();

    div = 4'd4; repeat (10) cycle();
    div = 4'd7; repeat (30) cycle();

    div = 4'd6; repeat (9) cycle();
    en  = 1'b0; repeat (20) cycle();
    en  = 1'b1; repeat (20) cycle();

    repeat (3) cycle();
    async_reset();
    repeat (3) cycle();
    reset = 1'b1;
    repeat (20) cycle();

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        div = DIV_W'($urandom_range(0, 15));
      end else if (r < 12) begin
        en = ~en;
      end else if (r == 12) begin
        async_reset();
        repeat (int'($urandom_range(1, 3))) cycle();
        reset = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
